ttt_turn_controller: RTL and testbench
======================================

Name: ttt_turn_controller

Overview:
- Game sequencer for the tic-tac-toe board. Owns the 3x3 board state and alternates move authority between the human button inputs and the AI block.
- Raises a request level to the AI while the AI is to move. Accepts exactly one legal move per turn and detects win/draw.
- Falls back to a default move if the AI does not answer in time.
- Sits between the debounced button inputs / AI outputs and the display/LED logic.

Parameters:
- AI_TIMEOUT, 1023, cycles in AI state without a legal AI move before a fallback move is forced (min 1).
- HUMAN_FIRST, 1, 1 = human (X) moves first after start; 0 = AI (O) moves first.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  reset, asynchronous, active-low
- start  input  1  single-cycle pulse; starts a game from IDLE or DONE
- human_press  input  9  cell press pulses from buttons, bit0=a .. bit8=i
- ai_press  input  9  cell press pulses from the AI, same mapping
- ai_turn  output  1  high while the controller waits for an AI move
- x_cells  output  9  cells owned by human
- o_cells  output  9  cells owned by AI
- winner  output  2  00 none, 01 X wins, 10 O wins, 11 draw
- game_over  output  1  high in DONE
- illegal  output  1  one-cycle pulse on a rejected press
- ai_forced  output  1  one-cycle pulse when the timeout fallback move is committed

Behaviour:
- Reset (async, any state, mid-game included): state=IDLE. x_cells=o_cells=0, winner=00, game_over=0, ai_turn=0, illegal=0, ai_forced=0, timeout counter=0.
- States: IDLE, HUMAN, AI, CHECK, DONE. A mover register records who moved last.
- IDLE: on start, clear board and winner. Go to HUMAN if HUMAN_FIRST=1, else AI.
- HUMAN: sample human_press each cycle.
  - Legal press = exactly one bit set, and that cell is free in (x_cells|o_cells).
  - Legal: set the bit in x_cells at the next edge; mover=X; go to CHECK.
  - Non-zero but not legal (multiple bits, or occupied cell): illegal pulses high next cycle; stay in HUMAN.
  - ai_press is ignored here.
- AI: ai_turn=1 (registered; high from the first AI-state cycle).
  - Same legality rule applied to ai_press; a legal move sets o_cells and goes to CHECK.
  - human_press is ignored.
  - Timeout counter increments each AI cycle and clears on entry.
  - When the counter reaches AI_TIMEOUT-1 with no legal press, commit the lowest-index free cell to o_cells, pulse ai_forced, go to CHECK.
  - If a legal press arrives in that same cycle, the press wins and ai_forced stays 0.
- CHECK: one cycle; ai_turn=0. Evaluate the registered board for the 8 lines (rows abc/def/ghi, columns adg/beh/cfi, diagonals aei/ceg), owner set = x_cells if mover=X, else o_cells.
  - Line complete: winner=01 (X) or 10 (O); go to DONE.
  - Else board full (x|o = 9'h1FF): winner=11; go to DONE.
  - Else go to the opposite mover's state (HUMAN or AI).
- DONE: game_over=1. The board and winner are held. All presses are ignored with no illegal pulse. start clears the board and re-enters as from IDLE.
- Move latency: legal press in cycle N → board bit visible at N+1 → CHECK at N+1 → next turn state or DONE at N+2.
- start in HUMAN/AI/CHECK is ignored. Only reset aborts a game.
- Board invariant: x_cells & o_cells == 0 always.

Optional Feature:
- Macro WIN_LINE_EN.
- Defined: extra output win_line[8:0]. It holds the cells of the completing line(s) when winner is 01/10, is 0 otherwise, and clears on reset or start. If a single move completes two lines, both are OR'd.
- Undefined: the port does not exist. No line-mask register is built, and the rest of the behaviour is unchanged.

Test Plan:
- Reset mid-game: after 3 moves, pulse reset low → x_cells=0, o_cells=0, state IDLE, ai_turn=0 asynchronously, before the next clk edge.
- X row win: HUMAN_FIRST=1, start; human a, AI d, human b, AI e, human c → winner=01, game_over=1 two cycles after the c press, x_cells=9'h007. With WIN_LINE_EN, win_line=9'h007.
- Illegal presses: in HUMAN, human_press=9'h003 → illegal pulse, board unchanged. Then press an occupied cell → illegal pulse. Then a free single cell → accepted.
- AI timeout: AI_TIMEOUT=8, X owns a → after 8 AI cycles with ai_press=0, o_cells=9'h002 and ai_forced pulses once. A legal ai_press in the 8th cycle instead commits that cell with ai_forced=0.
- Draw: move sequence X:a,O:b,X:c,O:e,X:d,O:f,X:h,O:g,X:i → winner=11, game_over=1, x|o=9'h1FF.
- Restart and ignore: in DONE, presses produce no board change or illegal pulse. start → board cleared, winner=00. With HUMAN_FIRST=0, ai_turn rises the first cycle after start.

Source files
------------

// File: rtl/ttt_turn_controller.sv
// Tic-tac-toe turn sequencer: owns the board, alternates human (X) and AI (O) moves, detects win/draw.
// Optional WIN_LINE_EN adds a win_line output holding the completing line mask.
module ttt_turn_controller #(
  parameter int unsigned AI_TIMEOUT  = 1023,
  parameter bit          HUMAN_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] human_press,
  input  logic [8:0] ai_press,
  output logic       ai_turn,
  output logic [8:0] x_cells,
  output logic [8:0] o_cells,
  output logic [1:0] winner,
  output logic       game_over,
  output logic       illegal,
  output logic       ai_forced
`ifdef WIN_LINE_EN
  ,
  output logic [8:0] win_line
`endif
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HUMAN,
    S_AI,
    S_CHECK,
    S_DONE
  } state_t;

  typedef enum logic {
    MV_X,
    MV_O
  } mover_t;

  localparam int unsigned CW = (AI_TIMEOUT < 2) ? 1 : $clog2(AI_TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(AI_TIMEOUT - 1);
  localparam state_t FIRST_STATE = HUMAN_FIRST ? S_HUMAN : S_AI;

  // rows abc/def/ghi, columns adg/beh/cfi, diagonals aei/ceg
  localparam logic [8:0] LINES [8] = '{
    9'h007, 9'h038, 9'h1C0,
    9'h049, 9'h092, 9'h124,
    9'h111, 9'h054
  };

  state_t        state, state_n;
  mover_t        mover, mover_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [8:0]    x_n, o_n;
  logic [1:0]    winner_n;
  logic          illegal_n, forced_n;
  logic [8:0]    occupied, free_cells, free_low;
  logic [8:0]    owner_cells, line_mask;
  logic          human_legal, ai_legal;
`ifdef WIN_LINE_EN
  logic [8:0]    win_line_n;
`endif

  function automatic logic one_hot9(input logic [8:0] v);
    return (v != '0) && ((v & (v - 9'd1)) == '0);
  endfunction

  function automatic logic [8:0] complete_lines(input logic [8:0] own);
    logic [8:0] m;
    m = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if ((own & LINES[i]) == LINES[i]) m = m | LINES[i];
    end
    return m;
  endfunction

  assign occupied    = x_cells | o_cells;
  assign free_cells  = ~occupied;
  // isolate the lowest set bit of the free-cell mask
  assign free_low    = free_cells & (~free_cells + 9'd1);
  assign human_legal = one_hot9(human_press) && ((human_press & occupied) == '0);
  assign ai_legal    = one_hot9(ai_press) && ((ai_press & occupied) == '0);
  assign owner_cells = (mover == MV_X) ? x_cells : o_cells;
  assign line_mask   = complete_lines(owner_cells);

  always_comb begin
    state_n   = state;
    mover_n   = mover;
    cnt_n     = '0;
    x_n       = x_cells;
    o_n       = o_cells;
    winner_n  = winner;
    illegal_n = 1'b0;
    forced_n  = 1'b0;
`ifdef WIN_LINE_EN
    win_line_n = win_line;
`endif
    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          x_n      = '0;
          o_n      = '0;
          winner_n = 2'b00;
`ifdef WIN_LINE_EN
          win_line_n = '0;
`endif
          state_n  = FIRST_STATE;
        end
      end
      S_HUMAN: begin
        if (human_press != '0) begin
          if (human_legal) begin
            x_n     = x_cells | human_press;
            mover_n = MV_X;
            state_n = S_CHECK;
          end else begin
            illegal_n = 1'b1;
          end
        end
      end
      S_AI: begin
        if (ai_legal) begin
          o_n     = o_cells | ai_press;
          mover_n = MV_O;
          state_n = S_CHECK;
        end else begin
          illegal_n = (ai_press != '0);
          if (cnt == CNT_LAST) begin
            o_n      = o_cells | free_low;
            mover_n  = MV_O;
            forced_n = 1'b1;
            state_n  = S_CHECK;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      S_CHECK: begin
        if (line_mask != '0) begin
          winner_n = (mover == MV_X) ? 2'b01 : 2'b10;
`ifdef WIN_LINE_EN
          win_line_n = line_mask;
`endif
          state_n  = S_DONE;
        end else if (occupied == '1) begin
          winner_n = 2'b11;
          state_n  = S_DONE;
        end else begin
          state_n = (mover == MV_X) ? S_AI : S_HUMAN;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      mover     <= MV_X;
      cnt       <= '0;
      x_cells   <= '0;
      o_cells   <= '0;
      winner    <= 2'b00;
      illegal   <= 1'b0;
      ai_forced <= 1'b0;
      ai_turn   <= 1'b0;
      game_over <= 1'b0;
`ifdef WIN_LINE_EN
      win_line  <= '0;
`endif
    end else begin
      state     <= state_n;
      mover     <= mover_n;
      cnt       <= cnt_n;
      x_cells   <= x_n;
      o_cells   <= o_n;
      winner    <= winner_n;
      illegal   <= illegal_n;
      ai_forced <= forced_n;
      ai_turn   <= (state_n == S_AI);
      game_over <= (state_n == S_DONE);
`ifdef WIN_LINE_EN
      win_line  <= win_line_n;
`endif
    end
  end

endmodule

// File: tb/tb_ttt_turn_controller.sv
// Scoreboard bench for ttt_turn_controller: a board-array game model predicts every cycle's outputs.
module tb_ttt_turn_controller;
  localparam int TO = 8;
  localparam int PH_IDLE = 0, PH_HUMAN = 1, PH_AI = 2, PH_CHECK = 3, PH_DONE = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic start2 = 1'b0;
  logic [8:0] human_press = '0, ai_press = '0, zero9 = '0;
  logic ai_turn, game_over, illegal, ai_forced;
  logic [8:0] x_cells, o_cells;
  logic [1:0] winner;
  logic ai_turn2, game_over2, illegal2, ai_forced2;
  logic [8:0] x_cells2, o_cells2;
  logic [1:0] winner2;
`ifdef WIN_LINE_EN
  logic [8:0] win_line, win_line2;
`endif

  always #5 clk = ~clk;

  ttt_turn_controller #(.AI_TIMEOUT(TO), .HUMAN_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .human_press(human_press), .ai_press(ai_press),
    .ai_turn(ai_turn), .x_cells(x_cells), .o_cells(o_cells), .winner(winner),
    .game_over(game_over), .illegal(illegal), .ai_forced(ai_forced)
`ifdef WIN_LINE_EN
    , .win_line(win_line)
`endif
  );

  ttt_turn_controller #(.AI_TIMEOUT(TO), .HUMAN_FIRST(1'b0)) dut_ai_first (
    .clk(clk), .reset(reset), .start(start2), .human_press(zero9), .ai_press(zero9),
    .ai_turn(ai_turn2), .x_cells(x_cells2), .o_cells(o_cells2), .winner(winner2),
    .game_over(game_over2), .illegal(illegal2), .ai_forced(ai_forced2)
`ifdef WIN_LINE_EN
    , .win_line(win_line2)
`endif
  );

  typedef struct packed {
    logic [8:0] x;
    logic [8:0] o;
    logic [1:0] w;
    logic       go;
    logic       at;
    logic       ill;
    logic       frc;
    logic [8:0] wl;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // reference model: board as cell owners (0 empty, 1 X, 2 O)
  int brd[9];
  int m_ph, m_last, m_tmr;
  logic [1:0] m_win;
  logic m_ill, m_frc;
  logic [8:0] m_wl;
  int lt[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  function automatic int cell_of(input logic [8:0] p);
    for (int i = 0; i < 9; i++) if (p[i]) return i;
    return -1;
  endfunction

  function automatic bit legal(input logic [8:0] p);
    if ($countones(p) != 1) return 1'b0;
    return brd[cell_of(p)] == 0;
  endfunction

  function automatic logic [8:0] lines_of(input int who);
    logic [8:0] m = '0;
    for (int l = 0; l < 8; l++)
      if (brd[lt[l][0]] == who && brd[lt[l][1]] == who && brd[lt[l][2]] == who) begin
        m[lt[l][0]] = 1'b1; m[lt[l][1]] = 1'b1; m[lt[l][2]] = 1'b1;
      end
    return m;
  endfunction

  function automatic bit board_full();
    for (int i = 0; i < 9; i++) if (brd[i] == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int first_free();
    for (int i = 0; i < 9; i++) if (brd[i] == 0) return i;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) brd[i] = 0;
    m_ph = PH_IDLE; m_last = 1; m_tmr = 0; m_win = 2'b00;
    m_ill = 1'b0; m_frc = 1'b0; m_wl = '0;
  endtask

  task automatic model_step(input logic [8:0] hp, input logic [8:0] ap, input logic st);
    logic [8:0] lm;
    m_ill = 1'b0; m_frc = 1'b0;
    case (m_ph)
      PH_IDLE, PH_DONE:
        if (st) begin
          for (int i = 0; i < 9; i++) brd[i] = 0;
          m_win = 2'b00; m_wl = '0; m_ph = PH_HUMAN;
        end
      PH_HUMAN:
        if (hp != 0) begin
          if (legal(hp)) begin brd[cell_of(hp)] = 1; m_last = 1; m_ph = PH_CHECK; end
          else m_ill = 1'b1;
        end
      PH_AI:
        if (ap != 0 && legal(ap)) begin
          brd[cell_of(ap)] = 2; m_last = 2; m_ph = PH_CHECK;
        end else begin
          if (ap != 0) m_ill = 1'b1;
          if (m_tmr == TO - 1) begin
            brd[first_free()] = 2; m_last = 2; m_frc = 1'b1; m_ph = PH_CHECK;
          end else m_tmr++;
        end
      default: begin
        lm = lines_of(m_last);
        if (lm != 0) begin
          m_win = (m_last == 1) ? 2'b01 : 2'b10; m_wl = lm; m_ph = PH_DONE;
        end else if (board_full()) begin
          m_win = 2'b11; m_ph = PH_DONE;
        end else begin
          m_ph = (m_last == 1) ? PH_AI : PH_HUMAN; m_tmr = 0;
        end
      end
    endcase
  endtask

  function automatic exp_t snap();
    exp_t e;
    for (int i = 0; i < 9; i++) begin
      e.x[i] = (brd[i] == 1);
      e.o[i] = (brd[i] == 2);
    end
    e.w = m_win; e.go = (m_ph == PH_DONE); e.at = (m_ph == PH_AI);
    e.ill = m_ill; e.frc = m_frc; e.wl = m_wl;
    return e;
  endfunction

  task automatic step(input logic [8:0] hp, input logic [8:0] ap, input logic st);
    @(negedge clk);
    human_press = hp; ai_press = ap; start = st;
    model_step(hp, ap, st);
    sb.push_back(snap());
  endtask

  task automatic move_h(input logic [8:0] p);
    step(p, '0, 1'b0); step('0, '0, 1'b0);
  endtask

  task automatic move_a(input logic [8:0] p);
    step('0, p, 1'b0); step('0, '0, 1'b0);
  endtask

  task automatic after_edge();
    @(posedge clk); #1;
  endtask

  task automatic reset_mid();
    @(negedge clk);
    human_press = '0; ai_press = '0; start = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst_x_cells", x_cells, 9'h000);
    chk("rst_o_cells", o_cells, 9'h000);
    chk("rst_ai_turn", {8'h00, ai_turn}, 9'h000);
    chk("rst_winner_go", {6'h00, winner, game_over}, 9'h000);
    @(negedge clk);
    reset = 1'b1;
    model_reset();
  endtask

  // monitor: every cycle with a pending expectation is compared after the edge
  initial begin
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_x_cells", x_cells, e.x);
        chk("sb_o_cells", o_cells, e.o);
        chk("sb_winner", {7'h00, winner}, {7'h00, e.w});
        chk("sb_game_over", {8'h00, game_over}, {8'h00, e.go});
        chk("sb_ai_turn", {8'h00, ai_turn}, {8'h00, e.at});
        chk("sb_illegal", {8'h00, illegal}, {8'h00, e.ill});
        chk("sb_ai_forced", {8'h00, ai_forced}, {8'h00, e.frc});
        chk("sb_invariant", x_cells & o_cells, 9'h000);
`ifdef WIN_LINE_EN
        chk("sb_win_line", win_line, e.wl);
`endif
      end
    end
  end

  initial begin
    logic [8:0] one = 9'h001;
    logic [8:0] hp, ap;
    logic st;
    int r;
    model_reset();
    repeat (3) @(negedge clk);
    chk("init_x_cells", x_cells, 9'h000);
    chk("init_flags", {5'h00, ai_turn, game_over, illegal, ai_forced}, 9'h000);
    reset = 1'b1;

    // AI-first instance: ai_turn the first cycle after start, fallback to cell a after TO cycles
    @(negedge clk); start2 = 1'b1;
    after_edge();
    chk("aifirst_ai_turn", {8'h00, ai_turn2}, 9'h001);
    @(negedge clk); start2 = 1'b0;
    repeat (TO - 1) after_edge();
    chk("aifirst_not_early", o_cells2, 9'h000);
    after_edge();
    chk("aifirst_forced_o", o_cells2, 9'h001);
    chk("aifirst_forced_pulse", {8'h00, ai_forced2}, 9'h001);
    after_edge();
    chk("aifirst_forced_once", {7'h00, ai_forced2, ai_turn2}, 9'h000);
    chk("aifirst_other", {x_cells2[6:0], winner2}, {illegal2, game_over2, 7'h00});

    // X row win
    step('0, '0, 1'b1);
    move_h(9'h001); move_a(9'h008); move_h(9'h002); move_a(9'h010);
    step(9'h004, '0, 1'b0); step('0, '0, 1'b0);
    after_edge();
    chk("xwin_winner", {7'h00, winner}, 9'h001);
    chk("xwin_game_over", {8'h00, game_over}, 9'h001);
    chk("xwin_x_cells", x_cells, 9'h007);
`ifdef WIN_LINE_EN
    chk("xwin_win_line", win_line, 9'h007);
`endif
    // presses in DONE are ignored
    step(9'h020, 9'h040, 1'b0); step(9'h1FF, 9'h003, 1'b0);
    after_edge();
    chk("done_ignore", {x_cells, illegal}, {9'h007, 1'b0});
    step('0, '0, 1'b1);
    after_edge();
    chk("restart_clear", {x_cells[6:0], winner}, 9'h000);

    // illegal presses
    step(9'h003, '0, 1'b0);
    after_edge();
    chk("ill_multi", {x_cells[7:0], illegal}, 9'h001);
    step('0, '0, 1'b0);
    move_h(9'h001); move_a(9'h002);
    step(9'h001, '0, 1'b0);
    after_edge();
    chk("ill_occupied", {8'h00, illegal}, 9'h001);
    step(9'h004, '0, 1'b0); step('0, '0, 1'b0);
    after_edge();
    chk("ill_then_ok", x_cells, 9'h005);
    reset_mid();

    // AI timeout fallback, then legal press in the last cycle
    step('0, '0, 1'b1);
    move_h(9'h001);
    repeat (TO) step('0, '0, 1'b0);
    after_edge();
    chk("to_forced_o", o_cells, 9'h002);
    chk("to_forced_pulse", {8'h00, ai_forced}, 9'h001);
    step('0, '0, 1'b0);
    move_h(9'h008);
    repeat (TO - 1) step('0, '0, 1'b0);
    step('0, 9'h010, 1'b0);
    after_edge();
    chk("to_press_wins", {o_cells[7:0], ai_forced}, {8'h12, 1'b0});
    step('0, '0, 1'b0);
    reset_mid();

    // draw
    step('0, '0, 1'b1);
    move_h(9'h001); move_a(9'h002); move_h(9'h004); move_a(9'h010); move_h(9'h008);
    move_a(9'h020); move_h(9'h080); move_a(9'h040);
    step(9'h100, '0, 1'b0); step('0, '0, 1'b0);
    after_edge();
    chk("draw_winner", {7'h00, winner}, 9'h003);
    chk("draw_full", x_cells | o_cells, 9'h1FF);
    chk("draw_game_over", {8'h00, game_over}, 9'h001);

    // randomized play
    for (int c = 0; c < 2500; c++) begin
      st = ($urandom_range(0, 15) == 0);
      r = $urandom_range(0, 9);
      if (r < 5) hp = '0;
      else if (r < 9) hp = one << $urandom_range(0, 8);
      else hp = 9'($urandom);
      r = $urandom_range(0, 11);
      if (r < 9) ap = '0;
      else if (r < 11) ap = one << $urandom_range(0, 8);
      else ap = 9'($urandom);
      step(hp, ap, st);
    end
    step('0, '0, 1'b0);
    repeat (2) @(posedge clk);
    #2;
    chk("sb_drained", 9'(sb.size()), 9'h000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
